// File: rtl/salu_pkg.sv
// Shared definitions for the scalar-ALU request arbiter: opcodes, widths and
// the buffered response slot payload.
package salu_pkg;

  localparam int unsigned SALU_OP_W       = 4;
  localparam int unsigned SALU_FLAG_W     = 3;
  localparam int unsigned SALU_MAX_DATA_W = 64;

  // Opcode map of the external scalar ALU
  localparam logic [SALU_OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [SALU_OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [SALU_OP_W-1:0] OP_SLL  = 4'd2;
  localparam logic [SALU_OP_W-1:0] OP_SLT  = 4'd3;
  localparam logic [SALU_OP_W-1:0] OP_SLTU = 4'd4;
  localparam logic [SALU_OP_W-1:0] OP_XOR  = 4'd5;
  localparam logic [SALU_OP_W-1:0] OP_SRL  = 4'd6;
  localparam logic [SALU_OP_W-1:0] OP_SRA  = 4'd7;
  localparam logic [SALU_OP_W-1:0] OP_OR   = 4'd8;
  localparam logic [SALU_OP_W-1:0] OP_AND  = 4'd9;
  localparam logic [SALU_OP_W-1:0] OP_BEQ  = 4'd10;
  localparam logic [SALU_OP_W-1:0] OP_BNE  = 4'd11;
  localparam logic [SALU_OP_W-1:0] OP_BLT  = 4'd12;
  localparam logic [SALU_OP_W-1:0] OP_BGE  = 4'd13;
  localparam logic [SALU_OP_W-1:0] OP_BLTU = 4'd14;
  localparam logic [SALU_OP_W-1:0] OP_BGEU = 4'd15;

  // Response slot; data is sized for the widest supported datapath
  typedef struct packed {
    logic [SALU_MAX_DATA_W-1:0] data;
    logic [SALU_FLAG_W-1:0]     flags;  // {overflow, negative, zero}
  } salu_slot_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant among eligible requesters, search starting at ptr.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c
);

  logic found;

  // First pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1
  always_comb begin
    grant_c = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && eligible[i] && (PTR_W'(i) >= ptr)) begin
        grant_c[i] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && eligible[i] && (PTR_W'(i) < ptr)) begin
        grant_c[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/salu_arbiter.sv
// Shares one registered scalar ALU among NUM_REQ requesters; each requester
// owns a single response slot that holds its result until accepted.
module salu_arbiter
  import salu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_rs1_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_rs2_i,
  input  logic [NUM_REQ*SALU_OP_W-1:0]    req_op_i,
  output logic [DATA_WIDTH-1:0]           alu_rs1_o,
  output logic [DATA_WIDTH-1:0]           alu_rs2_o,
  output logic [SALU_OP_W-1:0]            alu_op_o,
  input  logic [DATA_WIDTH-1:0]           alu_res_i,
  input  logic [SALU_FLAG_W-1:0]          alu_flags_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  input  logic [NUM_REQ-1:0]              rsp_ready_i,
  output logic [NUM_REQ*DATA_WIDTH-1:0]   rsp_data_o,
  output logic [NUM_REQ*SALU_FLAG_W-1:0]  rsp_flags_o,
  output logic                            busy_o
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   ptr_q;
  logic               inflight_v_q;
  logic [PTR_W-1:0]   inflight_id_q;
  logic [NUM_REQ-1:0] slot_v_q;
  salu_slot_t         slot_q [NUM_REQ];

  logic [NUM_REQ-1:0] eligible_c;
  logic [NUM_REQ-1:0] grant_c;
  logic               grant_any_c;
  logic [PTR_W-1:0]   grant_id_c;
  logic [PTR_W-1:0]   ptr_nxt_c;

  // A requester may issue only if its slot cannot be occupied when the result lands
  always_comb begin
    eligible_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_c[i] = rst_n && !flush_i && req_valid_i[i]
                   && !(inflight_v_q && (inflight_id_q == PTR_W'(i)))
                   && (!slot_v_q[i] || rsp_ready_i[i]);
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .eligible (eligible_c),
    .ptr      (ptr_q),
    .grant_c  (grant_c)
  );

  // Operand mux; idle ALU sees zero operands and ADD
  always_comb begin
    alu_rs1_o  = '0;
    alu_rs2_o  = '0;
    alu_op_o   = OP_ADD;
    grant_id_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        alu_rs1_o  = req_rs1_i[i*DATA_WIDTH +: DATA_WIDTH];
        alu_rs2_o  = req_rs2_i[i*DATA_WIDTH +: DATA_WIDTH];
        alu_op_o   = req_op_i[i*SALU_OP_W +: SALU_OP_W];
        grant_id_c = PTR_W'(i);
      end
    end
  end

  assign grant_any_c = |grant_c;
  assign req_ready_o = grant_c;
  assign ptr_nxt_c   = (grant_id_c == PTR_W'(NUM_REQ - 1)) ? '0 : grant_id_c + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      inflight_v_q  <= 1'b0;
      inflight_id_q <= '0;
      slot_v_q      <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= '0;
      end
    end else if (flush_i) begin
      // Pointer survives a flush so fairness is preserved
      inflight_v_q <= 1'b0;
      slot_v_q     <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      inflight_v_q  <= grant_any_c;
      inflight_id_q <= grant_id_c;
      if (grant_any_c) begin
        ptr_q <= ptr_nxt_c;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (inflight_v_q && (inflight_id_q == PTR_W'(i))) begin
          slot_v_q[i]     <= 1'b1;
          slot_q[i].data  <= SALU_MAX_DATA_W'(alu_res_i);
          slot_q[i].flags <= alu_flags_i;
        end else if (slot_v_q[i] && rsp_ready_i[i]) begin
          slot_v_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rsp_data_o  = '0;
    rsp_flags_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_data_o[i*DATA_WIDTH +: DATA_WIDTH]    = slot_q[i].data[DATA_WIDTH-1:0];
      rsp_flags_o[i*SALU_FLAG_W +: SALU_FLAG_W] = slot_q[i].flags;
    end
  end

  assign rsp_valid_o = slot_v_q;
  assign busy_o      = inflight_v_q | (|slot_v_q);

  // Slot bits above DATA_WIDTH are constant zero and intentionally unread
  if (DATA_WIDTH < SALU_MAX_DATA_W) begin : g_pad
    logic slot_pad_unused;
    always_comb begin
      slot_pad_unused = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_pad_unused = slot_pad_unused ^ (^slot_q[i].data[SALU_MAX_DATA_W-1:DATA_WIDTH]);
      end
    end
  end

endmodule

// File: tb/tb_salu_arbiter.sv
// Randomised and directed checks of salu_arbiter against a transaction-level
// model, with a registered behavioural ALU attached to the issue port.
module tb_salu_arbiter;
  import salu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned N  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_rs1;
  logic [N*DW-1:0]   req_rs2;
  logic [N*4-1:0]    req_op;
  logic [DW-1:0]     alu_rs1;
  logic [DW-1:0]     alu_rs2;
  logic [3:0]        alu_op;
  logic [DW-1:0]     alu_res;
  logic [2:0]        alu_flags;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [N*DW-1:0]   rsp_data;
  logic [N*3-1:0]    rsp_flags;
  logic              busy;

  always #5 clk = ~clk;

  salu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_op_i(req_op),
    .alu_rs1_o(alu_rs1), .alu_rs2_o(alu_rs2), .alu_op_o(alu_op),
    .alu_res_i(alu_res), .alu_flags_i(alu_flags),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_flags_o(rsp_flags), .busy_o(busy)
  );

  // Behavioural ALU: returns {ovf, neg, zero, result}
  function automatic logic [DW+2:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic          ovf;
    ovf = 1'b0;
    case (op)
      OP_ADD:  begin r = a + b; ovf = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
      OP_SUB:  begin r = a - b; ovf = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
      OP_SLL:  r = a << b[4:0];
      OP_SLT:  r = DW'($signed(a) < $signed(b));
      OP_SLTU: r = DW'(a < b);
      OP_XOR:  r = a ^ b;
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_BEQ:  r = DW'(a == b);
      OP_BNE:  r = DW'(a != b);
      OP_BLT:  r = DW'($signed(a) < $signed(b));
      OP_BGE:  r = DW'($signed(a) >= $signed(b));
      OP_BLTU: r = DW'(a < b);
      default: r = DW'(a >= b);
    endcase
    return {ovf, r[DW-1], (r == '0), r};
  endfunction

  always_ff @(posedge clk) {alu_flags, alu_res} <= alu_f(alu_op, alu_rs1, alu_rs2);

  // Transaction model: pointer, one pending issue, one held result per requester
  int            m_ptr;
  bit            m_inf_v;
  int            m_inf_id;
  logic [DW+2:0] m_inf_r;
  bit            m_sv [N];
  logic [DW+2:0] m_sr [N];

  int n_chk;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare one cycle against the model, advance the model, move to next cycle
  task automatic tick();
    int         g;
    int         idx;
    bit         ok;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      ok  = rst_n && !flush && req_valid[idx] && !(m_inf_v && m_inf_id == idx)
            && (!m_sv[idx] || rsp_ready[idx]);
      if (g < 0 && ok) g = idx;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    if (g >= 0) begin
      check("alu_rs1", alu_rs1, req_rs1[g*DW +: DW]);
      check("alu_rs2", alu_rs2, req_rs2[g*DW +: DW]);
      check("alu_op", alu_op, req_op[g*4 +: 4]);
    end else begin
      check("alu_idle", {alu_op, alu_rs2, alu_rs1}, '0);
    end
    for (int i = 0; i < N; i++) begin
      check($sformatf("rsp_valid%0d", i), rsp_valid[i], m_sv[i]);
      if (m_sv[i]) begin
        check($sformatf("rsp_data%0d", i), rsp_data[i*DW +: DW], m_sr[i][DW-1:0]);
        check($sformatf("rsp_flags%0d", i), rsp_flags[i*3 +: 3], m_sr[i][DW+2:DW]);
      end
    end
    check("busy", busy, m_inf_v || m_sv[0] || m_sv[1]);

    if (!rst_n) begin
      m_ptr = 0; m_inf_v = 0;
      for (int i = 0; i < N; i++) m_sv[i] = 0;
    end else if (flush) begin
      m_inf_v = 0;
      for (int i = 0; i < N; i++) m_sv[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) if (m_sv[i] && rsp_ready[i]) m_sv[i] = 0;
      if (m_inf_v) begin
        m_sv[m_inf_id] = 1;
        m_sr[m_inf_id] = m_inf_r;
      end
      m_inf_v = (g >= 0);
      if (g >= 0) begin
        m_inf_id = g;
        m_inf_r  = alu_f(req_op[g*4 +: 4], req_rs1[g*DW +: DW], req_rs2[g*DW +: DW]);
        m_ptr    = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_operands();
    for (int i = 0; i < N; i++) begin
      req_rs1[i*DW +: DW] = $urandom;
      req_rs2[i*DW +: DW] = $urandom;
      req_op[i*4 +: 4]    = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    m_ptr = 0; m_inf_v = 0; m_inf_id = 0; m_inf_r = '0;
    for (int i = 0; i < N; i++) begin m_sv[i] = 0; m_sr[i] = '0; end
    rst_n = 1'b0; flush = 1'b0; req_valid = '0; rsp_ready = '0;
    req_rs1 = '0; req_rs2 = '0; req_op = '0;
    tick();
    tick();
    check("rst_valid", rsp_valid, '0);
    check("rst_data", rsp_data, '0);
    check("rst_flags", rsp_flags, '0);
    check("rst_busy", busy, 1'b0);

    // Single ADD: accept in cycle 0, result visible in cycle 2
    rst_n = 1'b1; req_valid = 2'b01;
    req_rs1[DW-1:0] = 32'd5; req_rs2[DW-1:0] = 32'd7; req_op[3:0] = OP_ADD;
    #1 check("add_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    check("add_valid_c1", rsp_valid, 2'b00);
    tick();
    check("add_valid_c2", rsp_valid, 2'b01);
    check("add_data", rsp_data[DW-1:0], 32'd12);
    check("add_flags", rsp_flags[2:0], 3'b000);
    rsp_ready = 2'b11;
    tick();

    // Two busy requesters alternate at one issue per cycle
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_valid = 2'b11;
      rand_operands();
      #1 check($sformatf("alt_grant%0d", c), req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // Overflowing ADD held in its slot while the consumer stalls
    do_reset();
    rsp_ready = 2'b00; req_valid = 2'b01;
    req_rs1[DW-1:0] = 32'h7FFF_FFFF; req_rs2[DW-1:0] = 32'd1; req_op[3:0] = OP_ADD;
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      check("ovf_valid", rsp_valid[0], 1'b1);
      check("ovf_data", rsp_data[DW-1:0], 32'h8000_0000);
      check("ovf_flags", rsp_flags[2:0], 3'b110);
      check("ovf_no_grant", req_ready[0], 1'b0);
      tick();
    end
    rsp_ready = 2'b01;
    #1 check("ovf_regrant", req_ready, 2'b01);
    tick();
    req_valid = '0; rsp_ready = 2'b11;
    repeat (3) tick();

    // Flush drops the op issued the cycle before
    do_reset();
    rsp_ready = 2'b00; req_valid = 2'b10;
    rand_operands();
    tick();
    req_valid = '0; flush = 1'b1;
    #1 check("flush_busy_inflight", busy, 1'b1);
    tick();
    flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("flush_no_rsp1", rsp_valid[1], 1'b0);
      check("flush_idle", busy, 1'b0);
      tick();
    end

    // Reset with both slots full and pointer at 1
    req_valid = 2'b10; rand_operands();
    tick();
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick();
    check("full_slots", rsp_valid, 2'b11);
    do_reset();
    check("rst_mid_valid", rsp_valid, 2'b00);
    check("rst_mid_busy", busy, 1'b0);
    req_valid = 2'b11;
    #1 check("rst_mid_grant", req_ready, 2'b01);
    tick();
    req_valid = '0; rsp_ready = 2'b11;
    repeat (3) tick();

    // Random traffic with occasional flush and reset
    for (int c = 0; c < 1500; c++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      req_valid = N'($urandom);
      rsp_ready = N'($urandom | $urandom);
      if ($urandom_range(0, 3) != 0) rand_operands();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/salu_arbiter.md
SALU_ARBITER -- requirements
Module: salu_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning operand/result width.
REQ-002 SHALL have parameter NUM_REQ, default 2, meaning requester count; legal range 2..4.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port flush_i  input  1  discard all in-flight and buffered results.
REQ-006 SHALL have port req_valid_i  input  NUM_REQ  per-requester request valid.
REQ-007 SHALL have port req_ready_o  output  NUM_REQ  per-requester request accept.
REQ-008 SHALL have port req_rs1_i  input  NUM_REQ*DATA_WIDTH  operand A per requester, flattened, requester 0 in LSBs.
REQ-009 SHALL have port req_rs2_i  input  NUM_REQ*DATA_WIDTH  operand B per requester, flattened.
REQ-010 SHALL have port req_op_i  input  NUM_REQ*4  ALU opcode per requester.
REQ-011 SHALL have port alu_rs1_o  output  DATA_WIDTH  operand A to the scalar ALU.
REQ-012 SHALL have port alu_rs2_o  output  DATA_WIDTH  operand B to the scalar ALU.
REQ-013 SHALL have port alu_op_o  output  4  opcode to the scalar ALU.
REQ-014 SHALL have port alu_res_i  input  DATA_WIDTH  ALU registered result; valid one cycle after issue.
REQ-015 SHALL have port alu_flags_i  input  3  ALU registered {overflow, negative, zero}.
REQ-016 SHALL have port rsp_valid_o  output  NUM_REQ  per-requester result valid.
REQ-017 SHALL have port rsp_ready_i  input  NUM_REQ  per-requester result accept.
REQ-018 SHALL have port rsp_data_o  output  NUM_REQ*DATA_WIDTH  per-requester result, flattened.
REQ-019 SHALL have port rsp_flags_o  output  NUM_REQ*3  per-requester {overflow, negative, zero}.
REQ-020 SHALL have port busy_o  output  1  high while any operation is in flight or buffered.

Function
REQ-021 Transfer on either channel SHALL occur only on a cycle with valid and ready both high.
REQ-022 At most one req_ready_o bit SHALL be high per cycle; req_ready_o[i] SHALL imply req_valid_i[i].
REQ-023 Requester i SHALL be eligible iff valid, no in-flight op targets i, slot i is empty or rsp_ready_i[i] is high, and flush_i is low.
REQ-024 Among eligible requesters, grant SHALL be round-robin starting from priority pointer; after a grant to i, pointer SHALL become (i+1) mod NUM_REQ; pointer SHALL not move without a grant.
REQ-025 In the grant cycle, alu_rs1_o/alu_rs2_o/alu_op_o SHALL combinationally carry the granted requester's fields; with no grant they SHALL be zero, zero, 4'b0000 (ADD).
REQ-026 A grant SHALL set in-flight valid and in-flight id for exactly the next cycle.
REQ-027 In the cycle after a grant, alu_res_i/alu_flags_i SHALL be captured into result slot id at the clock edge ending that cycle.
REQ-028 rsp_valid_o[i] SHALL rise in the cycle two cycles after the accept cycle and hold, data/flags stable, until rsp_ready_i[i].
REQ-029 Slot drain and slot load for the same requester SHALL not coincide (guaranteed by REQ-023); drain of slot i with a load of slot j≠i SHALL both take effect.
REQ-030 Aggregate throughput SHALL reach one issue per cycle when requesters alternate with rsp_ready held high; a single requester SHALL reach one issue per two cycles.
REQ-031 flush_i high SHALL force req_ready_o to zero, clear all slots and in-flight valid at that edge, and drop the ALU result of any op in flight; pointer SHALL be retained.
REQ-032 busy_o SHALL equal in-flight valid OR any slot valid.

Reset
REQ-033 With rst_n low at a rising edge: rsp_valid_o=0, rsp_data_o=0, rsp_flags_o=0, in-flight valid=0, pointer=0, busy_o=0.
REQ-034 req_ready_o SHALL be zero while rst_n is low; an op in flight when reset asserts SHALL be discarded.

Structure
REQ-035 ALU opcode constants (ADD..BGEU, 4-bit) and a response-slot struct {data, flags} SHALL live in shared package salu_pkg.
REQ-036 Round-robin selection SHALL be a sub-module rr_arbiter (inputs eligible vector, pointer; outputs one-hot grant).
REQ-037 The scalar ALU SHALL be external; this block SHALL contain no arithmetic beyond pointer increment.

Verification
REQ-038 Reset then req0 {rs1=5, rs2=7, ADD} -> ready0 cycle 0, rsp_valid_o[0] cycle 2, data=12, flags=000.
REQ-039 Both valid continuously, rsp_ready=all-ones -> grants alternate 0,1,0,1; one issue per cycle; results matched per requester.
REQ-040 req0 {0x7FFFFFFF, 1, ADD}, rsp_ready0 low 5 cycles -> data 0x80000000, flags ovf=1 neg=1 held stable; no new grant to 0 until drained.
REQ-041 Issue to req1 then flush_i in next cycle -> rsp_valid_o[1] never rises, busy_o low after flush edge.
REQ-042 rst_n low for one cycle mid-stream with slots full -> all rsp_valid_o low, pointer 0, next grant goes to lowest valid index.
